// File: rtl/sd_bd_feeder.sv
// sd_bd_feeder: queues SD transfer requests and feeds each one to the SD controller
// as a two-word buffer descriptor over a Wishbone classic master port.
// Optional feature: define SD_BD_FEEDER_TIMEOUT_EN to add an ack timeout and err_o.

module sd_bd_feeder #(
  parameter logic [7:0]  ADR_BD_STATUS = 8'h50,
  parameter logic [7:0]  ADR_BD_TX     = 8'h80,
  parameter logic [7:0]  ADR_BD_RX     = 8'h60,
  parameter int unsigned POLL_GAP      = 16,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,

  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_dir_i,
  input  logic [31:0] req_sys_adr_i,
  input  logic [31:0] req_blk_adr_i,

  output logic [7:0]  m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  input  logic [31:0] m_wb_dat_i,
  output logic        m_wb_we_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  output logic [3:0]  m_wb_sel_o,
  input  logic        m_wb_ack_i,

  output logic [2:0]  pending_o,
`ifdef SD_BD_FEEDER_TIMEOUT_EN
  output logic        err_o,
`endif
  output logic        busy_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_STAT = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_WR_SYS  = 3'd3;
  localparam logic [2:0] S_WR_BLK  = 3'd4;

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  typedef struct packed {
    logic        dir;
    logic [31:0] sys_adr;
    logic [31:0] blk_adr;
  } req_t;

  if (POLL_GAP < 1 || POLL_GAP > 255) begin : g_bad_poll_gap
    $error("sd_bd_feeder: POLL_GAP must be in 1..255");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("sd_bd_feeder: TIMEOUT must be in 1..255");
  end

  // ---------------------------------------------------------------------------
  // Request FIFO (4 entries)
  // ---------------------------------------------------------------------------
  req_t       fifo_mem [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;
  logic       push;
  logic       pop;

  assign req_ready_o = (count_q != 3'd4);
  assign push        = req_valid_i && req_ready_o;

  // NOTE: the storage array has no reset; validity is carried by the reset pointers and count.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{dir: req_dir_i, sys_adr: req_sys_adr_i, blk_adr: req_blk_adr_i};
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  // ---------------------------------------------------------------------------
  // Descriptor FSM and Wishbone master
  // ---------------------------------------------------------------------------
  logic [2:0]  state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [7:0]  adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  req_t        cur_q;
  logic        cur_ld;
  logic        tmo_hit;
  logic [7:0]  free_cnt;
  logic [7:0]  bd_adr;
  logic        unused_dat;

  assign free_cnt   = cur_q.dir ? m_wb_dat_i[15:8] : m_wb_dat_i[7:0];
  assign bd_adr     = cur_q.dir ? ADR_BD_RX : ADR_BD_TX;
  assign unused_dat = ^m_wb_dat_i[31:16];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    wait_cnt_d = wait_cnt_q;
    cur_ld     = 1'b0;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != 3'd0) begin
          cur_ld  = 1'b1;
          state_d = S_RD_STAT;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = ADR_BD_STATUS;
          dat_d   = '0;
        end
      end

      S_RD_STAT: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b0;
          adr_d = ADR_BD_STATUS;
          dat_d = '0;
        end else if (m_wb_ack_i) begin
          cyc_d = 1'b0;
          if (free_cnt == 8'd0) begin
            state_d    = S_WAIT;
            wait_cnt_d = '0;
          end else begin
            state_d = S_WR_SYS;
          end
        end
      end

      // Re-read starts straight from the last idle cycle, so the bus gap is exactly POLL_GAP.
      S_WAIT: begin
        if (wait_cnt_q == GAP_LAST) begin
          state_d = S_RD_STAT;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = ADR_BD_STATUS;
          dat_d   = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_WR_SYS: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = bd_adr;
          dat_d = cur_q.sys_adr;
        end else if (m_wb_ack_i) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_WR_BLK;
        end
      end

      S_WR_BLK: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = bd_adr;
          dat_d = cur_q.blk_adr;
        end else if (m_wb_ack_i) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase

    // An abandoned cycle discards the request it belonged to.
    if (tmo_hit) begin
      state_d = S_IDLE;
      cyc_d   = 1'b0;
      we_d    = 1'b0;
      pop     = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= S_IDLE;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      wait_cnt_q <= '0;
      cur_q      <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      wait_cnt_q <= wait_cnt_d;
      if (cur_ld) cur_q <= fifo_mem[rd_ptr_q];
    end
  end

`ifdef SD_BD_FEEDER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] tmo_cnt_q;
  logic       err_q;

  assign tmo_hit = cyc_q && !m_wb_ack_i && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= (cyc_q && !m_wb_ack_i && !tmo_hit) ? tmo_cnt_q + 8'd1 : 8'd0;
      err_q     <= tmo_hit;
    end
  end

  assign err_o = err_q;
`else
  assign tmo_hit = 1'b0;
`endif

  assign m_wb_adr_o = adr_q;
  assign m_wb_dat_o = dat_q;
  assign m_wb_we_o  = we_q;
  assign m_wb_cyc_o = cyc_q;
  assign m_wb_stb_o = cyc_q;
  assign m_wb_sel_o = 4'hF;
  assign pending_o  = count_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule
